fp_addsub_rne: RTL
==================

Name: fp_addsub_rne

Overview:
- Multi-cycle, parametrised IEEE-754-style floating-point adder/subtractor.
- Successor to the single-precision start/done adder in the arithmetic datapath.
- Adds a subtract mode, round-to-nearest-even using guard/round/sticky bits, and correct NaN/Inf/zero handling.
- Adds exception flags and a busy output; one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit not stored).
- W (localparam), 1+EXP_W+MAN_W, operand/result width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch operation; samples a, b, op this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  1  0 = a+b, 1 = a-b (b sign inverted at capture).
- sum  out  W  result; valid while done=1.
- done  out  1  high from result cycle until next start or reset.
- busy  out  1  high from the cycle after start until done rises.
- flags  out  4  {invalid, overflow, underflow, inexact}; valid with done.

Behaviour:
- Reset: sum=0, done=0, busy=0, flags=0, FSM=IDLE. Reset mid-operation aborts with no result. Reset wins over start.
- start (any state, including busy) captures operands, clears done/flags, sets busy, enters SPECIAL. Restart discards the in-flight operation.
- Datapath is sign-magnitude. Working mantissa is {hidden, MAN_W fraction, G, R, S}, plus 1 carry bit.
- FSM:
  - IDLE: wait for start.
  - SPECIAL (1 cycle): classify operands, then resolve the special case or go to ALIGN.
  - ALIGN: shift the smaller-exponent mantissa right 1 bit/cycle; bits shifted out OR into S. If the exponent difference > MAN_W+3, collapse to S=(mantissa!=0) in one cycle.
  - ADDSUB (1 cycle): same effective sign adds; different effective sign subtracts smaller magnitude from larger. Result sign is the larger operand's sign.
  - NORM:
    - Carry out: shift right 1 (into sticky), exp+1, in 1 cycle.
    - Otherwise shift left 1 bit/cycle until hidden bit = 1, exp-1 per shift.
    - Zero mantissa: go to ROUND with zero.
  - ROUND (1 cycle): increment if G & (R | S | LSB). Mantissa overflow on increment gives exp+1. inexact = G|R|S.
  - DONE: drive sum/flags, done=1, busy=0; hold until start or reset.
- Exponent arithmetic carries 2 extra bits so over/underflow is detectable before packing.
- Special cases, resolved in SPECIAL, going straight to DONE:
  - Any NaN input, or Inf + (-Inf) effective: canonical qNaN {0, all-ones exp, 1 followed by zeros}, invalid=1.
  - One Inf: that Inf, with effective sign.
  - Denormal inputs (exp==0) are treated as signed zero (flush-to-zero).
  - Both zero: +0, except (-0)+(-0) = -0.
  - One zero: the other operand, with effective sign.
- Exact cancellation gives +0, inexact=0.
- Overflow (final exp ≥ all-ones): signed Inf, overflow=1, inexact=1.
- Underflow (final exp ≤ 0): signed zero (flush), underflow=1, inexact=1.
- Latency is start to done rising:
  - Special cases: 2 cycles.
  - Otherwise: 4 + alignment shifts + normalisation shifts.
  - Bounded by 2*MAN_W+12.

Test Plan:
- Default params, a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0 -> sum=0x40400000, flags=0, done held until next start.
- a=0x3F800000, b=0x3F800000, op=1 -> sum=0x00000000 (+0), flags=0; repeat with a=0x3F800001, b=0x3F800000, op=1 -> sum=0x34000000 after normalisation shifts.
- a=0x3F800000, b=0x33800000 (tie) -> sum=0x3F800000, inexact=1; b=0x33800001 -> sum=0x3F800001, inexact=1.
- a=b=0x7F7FFFFF, op=0 -> sum=0x7F800000, overflow=1, inexact=1; a=0x7F800000, b=0x7F800000, op=1 -> sum=0x7FC00000, invalid=1, latency 2.
- Pulse start with a=0x3F800000, b=0x00800000, then assert reset during ALIGN -> done=0, busy=0, sum=0; a new start then completes normally. A second start issued mid-operation returns only the second result.
- EXP_W=5, MAN_W=10: a=0x3C00, b=0x3C00 -> sum=0x4000; a=0x7BFF, b=0x7BFF -> sum=0x7C00, overflow=1.

Source files
------------

// File: rtl/fp_addsub_rne.sv
// fp_addsub_rne: multi-cycle floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero for denormals, NaN/Inf handling and exception flags.
module fp_addsub_rne #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   op,
   output logic [EXP_W+MAN_W:0]   sum,
   output logic                   done,
   output logic                   busy,
   output logic [3:0]             flags
);
   localparam int unsigned W   = 1 + EXP_W + MAN_W;
   localparam int unsigned MW  = MAN_W + 5;   // carry, hidden, fraction, G, R, S
   localparam int unsigned EW  = EXP_W + 2;   // two guard bits for over/underflow
   localparam int unsigned HID = MAN_W + 3;
   localparam int unsigned CRY = MAN_W + 4;

   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EW-1:0]    EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
   localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SPECIAL = 3'd1;
   localparam logic [2:0] S_ALIGN   = 3'd2;
   localparam logic [2:0] S_ADDSUB  = 3'd3;
   localparam logic [2:0] S_NORM    = 3'd4;
   localparam logic [2:0] S_ROUND   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0]       state, state_next;
   logic [W-1:0]     a_r, b_r;
   logic             sign_big, sign_small;
   logic [EW-1:0]    exp_r;
   logic [MW-1:0]    man_big, man_small;
   logic [EXP_W-1:0] diff;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic             a_ge;
   logic [EXP_W-1:0] exp_diff;
   logic [MW-1:0]    man_a, man_b;
   logic             spec_hit, spec_inv;
   logic [W-1:0]     spec_sum;
   logic             collapse;
   logic [MW-1:0]    add_res;
   logic             add_sign;
   logic             round_up, inexact;
   logic [MAN_W+1:0] rnd;
   logic [EW-1:0]    exp_fin;
   logic [MAN_W-1:0] frac_fin;
   logic [W-1:0]     res_sum;
   logic [3:0]       res_flags;

   assign {sa, ea, fa} = a_r;
   assign {sb, eb, fb} = b_r;
   assign a_nan  = (ea == EXP_ONES) && (fa != '0);
   assign b_nan  = (eb == EXP_ONES) && (fb != '0);
   assign a_inf  = (ea == EXP_ONES) && (fa == '0);
   assign b_inf  = (eb == EXP_ONES) && (fb == '0);
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_ge     = (ea >= eb);
   assign exp_diff = a_ge ? (ea - eb) : (eb - ea);
   assign man_a    = {1'b0, 1'b1, fa, 3'b000};
   assign man_b    = {1'b0, 1'b1, fb, 3'b000};
   assign collapse = (diff > EXP_W'(MAN_W + 3));

   // Special-operand resolution (NaN, Inf, flushed zeros)
   always_comb begin
      spec_hit = 1'b1;
      spec_inv = 1'b0;
      spec_sum = '0;
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
         spec_sum = QNAN;
         spec_inv = 1'b1;
      end else if (a_inf) begin
         spec_sum = a_r;
      end else if (b_inf) begin
         spec_sum = b_r;
      end else if (a_zero && b_zero) begin
         spec_sum = {sa & sb, (W-1)'(0)};
      end else if (a_zero) begin
         spec_sum = b_r;
      end else if (b_zero) begin
         spec_sum = a_r;
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Sign-magnitude add or subtract of the aligned mantissas
   always_comb begin
      add_res  = man_big + man_small;
      add_sign = sign_big;
      if (sign_big != sign_small) begin
         if (man_big >= man_small) begin
            add_res = man_big - man_small;
         end else begin
            add_res  = man_small - man_big;
            add_sign = sign_small;
         end
      end
   end

   // Round-to-nearest-even and final packing with range checks
   always_comb begin
      round_up  = man_big[2] & (man_big[1] | man_big[0] | man_big[3]);
      rnd       = {1'b0, man_big[HID:3]} + (MAN_W+2)'(round_up);
      exp_fin   = exp_r + EW'(rnd[MAN_W+1]);
      frac_fin  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      inexact   = |man_big[2:0];
      res_sum   = {sign_big, exp_fin[EXP_W-1:0], frac_fin};
      res_flags = {3'b000, inexact};
      if (man_big == '0) begin
         res_sum   = '0;
         res_flags = '0;
      end else if (!exp_fin[EW-1] && (exp_fin >= EXP_MAX)) begin
         res_sum   = {sign_big, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         res_flags = 4'b0101;
      end else if (exp_fin[EW-1] || (exp_fin == '0)) begin
         res_sum   = {sign_big, (W-1)'(0)};
         res_flags = 4'b0011;
      end
   end

   // Next-state logic; start restarts from any state
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    state_next = S_IDLE;
         S_SPECIAL: begin
            if (spec_hit)             state_next = S_DONE;
            else if (exp_diff != '0)  state_next = S_ALIGN;
            else                      state_next = S_ADDSUB;
         end
         S_ALIGN:   if (collapse || (diff == EXP_W'(1))) state_next = S_ADDSUB;
         S_ADDSUB: begin
            if ((add_res != '0) && (add_res[CRY] || !add_res[HID])) state_next = S_NORM;
            else                                                    state_next = S_ROUND;
         end
         S_NORM:    if (man_big[CRY] || man_big[HID-1]) state_next = S_ROUND;
         S_ROUND:   state_next = S_DONE;
         S_DONE:    state_next = S_DONE;
         default:   state_next = S_IDLE;
      endcase
      if (start) state_next = S_SPECIAL;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r        <= '0;
         b_r        <= '0;
         sign_big   <= 1'b0;
         sign_small <= 1'b0;
         exp_r      <= '0;
         man_big    <= '0;
         man_small  <= '0;
         diff       <= '0;
         sum        <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         flags      <= '0;
      end else if (start) begin
         a_r   <= a;
         b_r   <= {b[W-1] ^ op, b[W-2:0]};
         done  <= 1'b0;
         busy  <= 1'b1;
         flags <= '0;
      end else begin
         case (state)
            S_SPECIAL: begin
               if (spec_hit) begin
                  sum   <= spec_sum;
                  flags <= {spec_inv, 3'b000};
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else if (a_ge) begin
                  man_big    <= man_a;
                  man_small  <= man_b;
                  sign_big   <= sa;
                  sign_small <= sb;
                  exp_r      <= {2'b00, ea};
               end else begin
                  man_big    <= man_b;
                  man_small  <= man_a;
                  sign_big   <= sb;
                  sign_small <= sa;
                  exp_r      <= {2'b00, eb};
               end
               diff <= exp_diff;
            end
            S_ALIGN: begin
               if (collapse) begin
                  man_small <= MW'(1);
               end else begin
                  man_small <= (man_small >> 1) | MW'(man_small[0]);
                  diff      <= diff - EXP_W'(1);
               end
            end
            S_ADDSUB: begin
               man_big  <= add_res;
               sign_big <= add_sign;
            end
            S_NORM: begin
               if (man_big[CRY]) begin
                  man_big <= (man_big >> 1) | MW'(man_big[0]);
                  exp_r   <= exp_r + EW'(1);
               end else begin
                  man_big <= man_big << 1;
                  exp_r   <= exp_r - EW'(1);
               end
            end
            S_ROUND: begin
               sum   <= res_sum;
               flags <= res_flags;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
